uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver.
//  - Supports configurable data width, optional even/odd parity, 1 or 2 stop bits and oversampling rate.
//  - Holds each received word behind a valid/ack handshake.
//  - Reports frame, parity, break and overrun errors.
//  - Sits between the baud-tick generator and the command/FIFO layer.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, LSB first on the line
//  OVERSAMPLE  16  tick_os pulses per bit period, even, legal 4..32
//  PARITY_EN   0   1 = a parity bit follows the data bits
//  PARITY_ODD  0   with PARITY_EN=1: 0 = even parity, 1 = odd parity
//  STOP_BITS   1   1 or 2 stop bits checked
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-high reset
//  serial_in     in   1          asynchronous RX line, idle high
//  tick_os       in   1          one-clk pulse, OVERSAMPLE per bit period
//  rx_ack        in   1          consumer acknowledges the held word
//  data_out      out  DATA_BITS  last good word
//  rx_valid      out  1          data_out holds an unacknowledged word
//  data_ready_pulse out 1        one-clk pulse at end of every frame, good or bad
//  error_frame   out  1          a stop bit sampled low
//  error_parity  out  1          parity mismatch; word still delivered
//  error_break   out  1          data, parity and stop bits all low
//  error_overrun out  1          good word lost because rx_valid was still set
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, counters 0, both sync flops 1.
//    Reset mid-frame abandons the frame with no pulse and no flags.
//  - Synchronisation: serial_in passes through 2 flops (r1, r2).
//    falling_edge = ~r1 & r2. All sampling uses r2.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
//    Tick counter counts tick_os only; the bit counter holds the bit index.
//  - IDLE: on falling_edge -> START, tick count = 0.
//  - START: on the (OVERSAMPLE/2)-th tick, sample r2.
//    0 -> DATA; bit index = 0; clear error_frame, error_parity and error_break.
//    1 -> glitch, back to IDLE, no pulse.
//  - DATA: sample every OVERSAMPLE ticks and shift in LSB first.
//    After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
//  - PARITY: sample 1 bit after OVERSAMPLE ticks.
//    mismatch = ^{data, p} != PARITY_ODD.
//  - STOP: sample STOP_BITS bits, OVERSAMPLE ticks apart.
//    Any low stop sample -> frame bad. Always go to DONE after the last stop bit.
//  - DONE: lasts 1 clk. data_ready_pulse = 1, then back to IDLE.
//    Latency: last stop sample -> pulse = 1 clk.
//  - Flag updates in DONE:
//    error_frame = any stop sample low.
//    error_break = error_frame & data == 0 & (no parity or parity bit == 0).
//    error_parity = mismatch (0 if PARITY_EN = 0).
//    Frame, parity and break flags hold until the next accepted start bit.
//  - Good frame (error_frame = 0) in DONE:
//    If rx_valid = 0, or rx_ack = 1 in the same clk: data_out <= word, rx_valid <= 1.
//    Otherwise: word discarded, data_out unchanged, error_overrun <= 1.
//  - Bad frame: data_out and rx_valid unchanged; no overrun is raised.
//  - Handshake: rx_ack with rx_valid = 1 clears rx_valid and error_overrun
//    next clk, unless DONE reloads in the same clk. rx_ack with rx_valid = 0 is ignored.
//  - Data width: DATA_BITS < 8 pads nothing; the port width is exactly DATA_BITS.
//  - tick_os while in DONE or IDLE does not affect the counters.
//  - A new falling edge is honoured only in IDLE, i.e. the clk after DONE.
// TESTING
//  1. 8N1, OS=16: send 0xA5 -> data_out=0xA5, rx_valid=1, one data_ready_pulse, all errors 0.
//  2. 8E1: send 0x03 with parity bit 1 -> data_out=0x03, error_parity=1, rx_valid=1.
//  3. 8N1: line low for 10 bit periods -> error_frame=1, error_break=1, data_out unchanged, rx_valid unchanged.
//  4. 8N1: send 0x11 then 0x22 with no rx_ack -> data_out=0x11, error_overrun=1.
//     Then pulse rx_ack -> rx_valid=0, error_overrun=0.
//  5. Line low for 5 ticks, then high (OS=16) -> no pulse, FSM back in IDLE.
//     A following 0x5A is received correctly.
//  6. DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2: send 0x7F, parity 0.
//     Second stop bit low -> error_frame=1. Resend with a good stop -> data_out=0x7F, no errors.
//     Also assert reset mid-DATA -> all outputs 0, no pulse.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// OVERSAMPLE ticks per bit, with a valid/ack hold register and error flags.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 tick_os,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 data_ready_pulse,
  output logic                 error_frame,
  output logic                 error_parity,
  output logic                 error_break,
  output logic                 error_overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);
  localparam logic          LAST_S = 1'(STOP_BITS - 1);
  localparam logic          PEN    = (PARITY_EN != 0);
  localparam logic          PODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                 state_q;
  logic                   r1_q, r2_q;
  logic [TW-1:0]          tick_q;
  logic [BW-1:0]          bit_q;
  logic                   stop_q, stop_bad_q, par_q;
  logic [DATA_BITS-1:0]   shift_q, data_q;
  logic                   valid_q, pulse_q, fe_q, pe_q, be_q, oe_q;
  logic                   fall_d;

  assign fall_d = ~r1_q & r2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q <= 1'b1;
      r2_q <= 1'b1;
    end else begin
      r1_q <= serial_in;
      r2_q <= r1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      stop_bad_q <= 1'b0;
      par_q      <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      be_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      // A reload in DONE below overrides this clear of rx_valid.
      if (rx_ack && valid_q) begin
        valid_q <= 1'b0;
        oe_q    <= 1'b0;
      end
      case (state_q)
        IDLE: if (fall_d) begin
          state_q <= START;
          tick_q  <= '0;
        end
        START: if (tick_os) begin
          if (tick_q == HALF_T) begin
            tick_q <= '0;
            if (!r2_q) begin
              state_q    <= DATA;
              bit_q      <= '0;
              stop_bad_q <= 1'b0;
              fe_q       <= 1'b0;
              pe_q       <= 1'b0;
              be_q       <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else tick_q <= tick_q + 1'b1;
        end
        DATA: if (tick_os) begin
          if (tick_q == FULL_T) begin
            tick_q  <= '0;
            shift_q <= {r2_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_B) begin
              state_q <= PEN ? PARITY : STOP;
              stop_q  <= 1'b0;
            end else bit_q <= bit_q + 1'b1;
          end else tick_q <= tick_q + 1'b1;
        end
        PARITY: if (tick_os) begin
          if (tick_q == FULL_T) begin
            tick_q  <= '0;
            par_q   <= r2_q;
            state_q <= STOP;
          end else tick_q <= tick_q + 1'b1;
        end
        STOP: if (tick_os) begin
          if (tick_q == FULL_T) begin
            tick_q <= '0;
            if (!r2_q) stop_bad_q <= 1'b1;
            if (stop_q == LAST_S) state_q <= DONE;
            else stop_q <= 1'b1;
          end else tick_q <= tick_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          pulse_q <= 1'b1;
          fe_q    <= stop_bad_q;
          be_q    <= stop_bad_q && (shift_q == '0) && (!PEN || !par_q);
          pe_q    <= PEN && ((^{shift_q, par_q}) != PODD);
          if (!stop_bad_q) begin
            if (!valid_q || rx_ack) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else oe_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out         = data_q;
  assign rx_valid         = valid_q;
  assign data_ready_pulse = pulse_q;
  assign error_frame      = fe_q;
  assign error_parity     = pe_q;
  assign error_break      = be_q;
  assign error_overrun    = oe_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Two receivers (8N1 OS=16 and 7-bit odd parity, 2 stop, OS=8) driven with
// directed and random frames; a frame-level model feeds per-receiver scoreboards.
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       reset;
  logic       tick_os;
  logic [1:0] ser, ack;
  logic [7:0] doA;
  logic [6:0] doB;
  logic [1:0] vld, pls, fe, pe, be, oe;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
    .clk(clk), .reset(reset), .serial_in(ser[0]), .tick_os(tick_os), .rx_ack(ack[0]),
    .data_out(doA), .rx_valid(vld[0]), .data_ready_pulse(pls[0]), .error_frame(fe[0]),
    .error_parity(pe[0]), .error_break(be[0]), .error_overrun(oe[0]));

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dutB (
    .clk(clk), .reset(reset), .serial_in(ser[1]), .tick_os(tick_os), .rx_ack(ack[1]),
    .data_out(doB), .rx_valid(vld[1]), .data_ready_pulse(pls[1]), .error_frame(fe[1]),
    .error_parity(pe[1]), .error_break(be[1]), .error_overrun(oe[1]));

  typedef struct packed {
    logic [8:0] data;
    logic valid, fe, pe, be, oe;
  } exp_t;

  exp_t qA[$], qB[$];
  exp_t eA, eB;
  logic [8:0] m_data [2];
  logic       m_valid[2];
  logic       m_oe   [2];
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // tick_os: one pulse every 4 clocks
  initial begin
    int ph = 0;
    tick_os = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      tick_os = (ph == 0);
    end
  end

  always @(negedge clk) begin
    if (pls[0]) begin
      if (qA.size() == 0) chk("A_unexpected_pulse", 32'd1, 32'd0);
      else begin
        eA = qA.pop_front();
        chk("A_data", 32'(doA), 32'(eA.data));
        chk("A_valid", 32'(vld[0]), 32'(eA.valid));
        chk("A_frame", 32'(fe[0]), 32'(eA.fe));
        chk("A_parity", 32'(pe[0]), 32'(eA.pe));
        chk("A_break", 32'(be[0]), 32'(eA.be));
        chk("A_overrun", 32'(oe[0]), 32'(eA.oe));
      end
    end
    if (pls[1]) begin
      if (qB.size() == 0) chk("B_unexpected_pulse", 32'd1, 32'd0);
      else begin
        eB = qB.pop_front();
        chk("B_data", 32'(doB), 32'(eB.data));
        chk("B_valid", 32'(vld[1]), 32'(eB.valid));
        chk("B_frame", 32'(fe[1]), 32'(eB.fe));
        chk("B_parity", 32'(pe[1]), 32'(eB.pe));
        chk("B_break", 32'(be[1]), 32'(eB.be));
        chk("B_overrun", 32'(oe[1]), 32'(eB.oe));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (tick_os !== 1'b1);
    end
    #1;
  endtask

  task automatic drive_frame(input int i, input logic [8:0] d, input logic p,
                             input logic s0, input logic s1);
    int os = (i == 0) ? 16 : 8;
    int nb = (i == 0) ? 8 : 7;
    wait_ticks(1);
    ser[i] = 1'b0;
    wait_ticks(os);
    for (int b = 0; b < nb; b++) begin
      ser[i] = d[b];
      wait_ticks(os);
    end
    if (i == 1) begin ser[i] = p; wait_ticks(os); end
    ser[i] = s0;
    wait_ticks(os);
    if (i == 1) begin ser[i] = s1; wait_ticks(os); end
    ser[i] = 1'b1;
    wait_ticks(2 * os);
  endtask

  // Frame-level reference: outcome follows from the bits sent and the held word.
  task automatic send(input int i, input logic [8:0] d, input logic p,
                      input logic s0, input logic s1);
    exp_t e;
    logic [8:0] w;
    logic f, pb, bk;
    w  = (i == 0) ? {1'b0, d[7:0]} : {2'b00, d[6:0]};
    f  = !s0 || (i == 1 && !s1);
    bk = f && (w == 9'd0) && (i == 0 || !p);
    pb = (i == 1) && ((^{w[6:0], p}) != 1'b1);
    if (!f) begin
      if (!m_valid[i]) begin m_data[i] = w; m_valid[i] = 1'b1; end
      else m_oe[i] = 1'b1;
    end
    e.data = m_data[i]; e.valid = m_valid[i]; e.fe = f; e.pe = pb; e.be = bk; e.oe = m_oe[i];
    if (i == 0) qA.push_back(e); else qB.push_back(e);
    drive_frame(i, d, p, s0, s1);
  endtask

  task automatic do_ack(input int i);
    @(posedge clk); #1;
    ack[i] = 1'b1;
    @(posedge clk); #1;
    ack[i] = 1'b0;
    if (m_valid[i]) begin m_valid[i] = 1'b0; m_oe[i] = 1'b0; end
    chk(i == 0 ? "A_ack_valid" : "B_ack_valid", 32'(vld[i]), 32'(m_valid[i]));
    chk(i == 0 ? "A_ack_overrun" : "B_ack_overrun", 32'(oe[i]), 32'(m_oe[i]));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_A_data", 32'(doA), 32'd0);
    chk("rst_B_data", 32'(doB), 32'd0);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_pulse", 32'(pls), 32'd0);
    chk("rst_flags", 32'({fe, pe, be, oe}), 32'd0);
  endtask

  function automatic logic odd_p(input logic [8:0] d);
    return ~(^d[6:0]);
  endfunction

  initial begin
    logic [8:0] d;
    logic p, s0, s1;
    int i, r;
    reset = 1'b1; ser = 2'b11; ack = 2'b00;
    for (int k = 0; k < 2; k++) begin m_data[k] = '0; m_valid[k] = 1'b0; m_oe[k] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    reset = 1'b0;
    wait_ticks(4);

    send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);           // clean 8N1 word
    send(1, 9'h003, 1'b0, 1'b1, 1'b1);           // odd parity should be 1: mismatch
    send(0, 9'h000, 1'b0, 1'b0, 1'b1);           // line low for whole frame: break
    do_ack(0);
    send(0, 9'h011, 1'b0, 1'b1, 1'b1);
    send(0, 9'h022, 1'b0, 1'b1, 1'b1);           // overrun, 0x11 kept
    do_ack(0);
    wait_ticks(1);                               // 5-tick glitch: no frame
    ser[0] = 1'b0; wait_ticks(5); ser[0] = 1'b1; wait_ticks(40);
    send(0, 9'h05A, 1'b0, 1'b1, 1'b1);
    do_ack(1);
    send(1, 9'h07F, 1'b0, 1'b1, 1'b0);           // second stop low
    send(1, 9'h07F, 1'b0, 1'b1, 1'b1);
    send(1, 9'h000, 1'b0, 1'b0, 1'b0);           // break with parity bit 0

    // reset in the middle of a B frame: abandoned, no pulse
    wait_ticks(1);
    ser[1] = 1'b0; wait_ticks(8 * 3);
    reset = 1'b1; ser[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin m_data[k] = '0; m_valid[k] = 1'b0; m_oe[k] = 1'b0; end
    wait_ticks(40);

    for (int n = 0; n < 40; n++) begin
      i  = int'($urandom_range(0, 1));
      d  = 9'($urandom);
      r  = int'($urandom_range(0, 9));
      s0 = (r != 1);
      s1 = (r != 2);
      p  = odd_p(d) ^ ($urandom_range(0, 3) == 0);
      if (r == 0) begin d = '0; p = 1'b0; s0 = 1'b0; s1 = 1'b0; end
      send(i, d, p, s0, s1);
      if ($urandom_range(0, 2) == 0) do_ack(int'($urandom_range(0, 1)));
    end

    wait_ticks(20);
    chk("A_all_frames_seen", 32'(qA.size()), 32'd0);
    chk("B_all_frames_seen", 32'(qB.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
